booth_mult_seq_ctrl: RTL

//  Sequencing controller for the signed 8x8 multiplier path. Runs a radix-2 Booth shift-add

---
 rtl/mult_pkg.sv | 18 +
 rtl/booth_step.sv | 29 ++
 rtl/booth_mult_seq_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier: operand width and FSM encodings.
package mult_pkg;

    localparam int MULT_WIDTH = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] ITER = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_LOAD = LOAD,
        ST_ITER = ITER,
        ST_DONE = DONE
    } state_e;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then arithmetic shift of {A,Q,q_1}.
module booth_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH:0]   m_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc_i;
        case ({q_i[0], q1_i})
            2'b01:   sum = acc_i + m_i;
            2'b10:   sum = acc_i - m_i;
            default: sum = acc_i;
        endcase
        // A carries one guard bit, so the shifted-in sign is always the true sign.
        acc_o = {sum[WIDTH], sum[WIDTH:1]};
        q_o   = {sum[0], q_i[WIDTH-1:1]};
        q1_o  = q_i[0];
    end

endmodule

// File: rtl/booth_mult_seq_ctrl.sv
// Sequencing controller for a signed WIDTHxWIDTH Booth multiplier with start/busy/done handshake.
// Accept -> done pulse in WIDTH+2 cycles; start outside IDLE is dropped, product register loads on done.
module booth_mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               prod_load,
    output logic [2*WIDTH-1:0] product
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q1_q, q1_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH:0]     step_acc;
    logic [WIDTH-1:0]   step_q;
    logic               step_q1;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i (acc_q),
        .m_i   (m_q),
        .q_i   (q_q),
        .q1_i  (q1_q),
        .acc_o (step_acc),
        .q_o   (step_q),
        .q1_o  (step_q1)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        q1_d      = q1_q;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = {a[WIDTH-1], a};
                    q_d     = b;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy    = 1'b1;
                acc_d   = '0;
                q1_d    = 1'b0;
                count_d = CNT_W'(WIDTH);
                state_d = ST_ITER;
            end
            ST_ITER: begin
                busy    = 1'b1;
                acc_d   = step_acc;
                q_d     = step_q;
                q1_d    = step_q1;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        prod_load = done;
        product_d = prod_load ? {acc_q[WIDTH-1:0], q_q} : product_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule
